// File: rtl/hsyncfifo_pkg.sv
// hsyncfifo_pkg: shared types, defaults and helpers for the FWFT line-buffer FIFO.
// Contents: default geometry constants, prefetch occupancy type, level width function.
package hsyncfifo_pkg;

    // Geometry used by the Sobel line-buffer instances
    localparam int unsigned DEF_DATA_W   = 24;
    localparam int unsigned DEF_DEPTH    = 2048;
    localparam int unsigned DEF_AFULL_TH = 1920;

    // Words held in the head/skid prefetch stage (0..2)
    typedef logic [1:0] pf_occ_t;

    // Fill level covers core (DEPTH) + prefetch stage (2), so 0..DEPTH+2
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/hsyncfifo_if.sv
// hsyncfifo_if: write/pop handshake and status bundle of hsyncfifo_fwft.
// master: producer/consumer side (drives we, di, re); slave: the FIFO.
// Signals: we, di, re -> FIFO; dout, valid, empty_flag, full_flag, afull, level <- FIFO.
// With HSYNCFIFO_ERR_FLAG_EN defined, sticky ovf/udf are added.
interface hsyncfifo_if
    import hsyncfifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
);
    localparam int unsigned LVL_W = level_w(DEPTH);

    logic              we;
    logic [DATA_W-1:0] di;
    logic              re;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              empty_flag;
    logic              full_flag;
    logic              afull;
    logic [LVL_W-1:0]  level;
`ifdef HSYNCFIFO_ERR_FLAG_EN
    logic              ovf;
    logic              udf;

    modport master (output we, di, re,
                    input  dout, valid, empty_flag, full_flag, afull, level, ovf, udf);
    modport slave  (input  we, di, re,
                    output dout, valid, empty_flag, full_flag, afull, level, ovf, udf);
`else
    modport master (output we, di, re,
                    input  dout, valid, empty_flag, full_flag, afull, level);
    modport slave  (input  we, di, re,
                    output dout, valid, empty_flag, full_flag, afull, level);
`endif

endinterface

// File: rtl/hsyncfifo_ram.sv
// hsyncfifo_ram: simple dual-port RAM, DATA_W x DEPTH, registered 1-cycle read.
// Ports: clk; we/waddr/wdata write port; re/raddr read port; rdata valid the
// cycle after re. The array has no reset.
module hsyncfifo_ram #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned DEPTH  = 2048
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/hsyncfifo_fwft.sv
// hsyncfifo_fwft: first-word-fall-through synchronous FIFO for Sobel line buffers.
// Ports: clk, rst (sync, active-high), bus (hsyncfifo_if.slave).
// Core RAM feeds a head+skid prefetch stage so dout/valid are registered and a
// pop per cycle is sustained. Define HSYNCFIFO_ERR_FLAG_EN for sticky ovf/udf.
module hsyncfifo_fwft
    import hsyncfifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AFULL_TH = DEF_AFULL_TH
) (
    input  logic       clk,
    input  logic       rst,
    hsyncfifo_if.slave bus
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned LVL_W = level_w(DEPTH);

    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     core_cnt, core_cnt_d;
    logic              inflight;
    logic [DATA_W-1:0] head_q, head_d, skid_q, skid_d;
    logic              head_vld, head_vld_d, skid_vld, skid_vld_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full_q, afull_q, empty_q;
    logic [DATA_W-1:0] ram_rdata;

    logic              wr_acc_c, pop_c, rd_issue_c;
    pf_occ_t           occ_c;
    logic [2:0]        demand_c;

    // Accept/pop decisions are made on registered flags only
    assign wr_acc_c = bus.we & ~full_q;
    assign pop_c    = bus.re & head_vld;
    assign occ_c    = pf_occ_t'(head_vld) + pf_occ_t'(skid_vld);
    assign demand_c = 3'(occ_c) + 3'(inflight);
    // Read only if the word still fits in the prefetch stage when it returns
    assign rd_issue_c = (core_cnt != '0) && (demand_c < (3'(2) + 3'(pop_c)));

    hsyncfifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc_c),
        .waddr (wr_ptr),
        .wdata (bus.di),
        .re    (rd_issue_c),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Prefetch stage next state: pop shifts skid to head, returning data fills the first free slot
    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld;
        skid_d     = skid_q;
        skid_vld_d = skid_vld;
        if (pop_c) begin
            head_vld_d = skid_vld;
            head_d     = skid_vld ? skid_q : head_q;
            skid_vld_d = 1'b0;
        end
        if (inflight) begin
            if (!head_vld_d) begin
                head_d     = ram_rdata;
                head_vld_d = 1'b1;
            end else begin
                skid_d     = ram_rdata;
                skid_vld_d = 1'b1;
            end
        end
    end

    // Counts and flags for the next edge
    always_comb begin
        core_cnt_d = core_cnt + CW'(wr_acc_c) - CW'(rd_issue_c);
        level_d    = level_q + LVL_W'(wr_acc_c) - LVL_W'(pop_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            core_cnt <= '0;
            inflight <= 1'b0;
            head_q   <= '0;
            head_vld <= 1'b0;
            skid_q   <= '0;
            skid_vld <= 1'b0;
            level_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_acc_c)   wr_ptr <= wr_ptr + AW'(1);
            if (rd_issue_c) rd_ptr <= rd_ptr + AW'(1);
            core_cnt <= core_cnt_d;
            inflight <= rd_issue_c;
            head_q   <= head_d;
            head_vld <= head_vld_d;
            skid_q   <= skid_d;
            skid_vld <= skid_vld_d;
            level_q  <= level_d;
            full_q   <= (core_cnt_d == CW'(DEPTH));
            afull_q  <= (level_d >= LVL_W'(AFULL_TH));
            empty_q  <= ~head_vld_d;
        end
    end

    assign bus.dout       = head_q;
    assign bus.valid      = head_vld;
    assign bus.empty_flag = empty_q;
    assign bus.full_flag  = full_q;
    assign bus.afull      = afull_q;
    assign bus.level      = level_q;

`ifdef HSYNCFIFO_ERR_FLAG_EN
    logic ovf_q, udf_q;

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.we & full_q)    ovf_q <= 1'b1;
            if (bus.re & ~head_vld) udf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
    assign bus.udf = udf_q;
`endif

endmodule

// File: tb/tb_hsyncfifo_fwft.sv
// tb_hsyncfifo_fwft: scoreboard bench for hsyncfifo_fwft (DEPTH=16, AFULL_TH=10).
// Writes push expected words into a queue; a negedge monitor pops and compares
// on every DUT pop. Directed sequences cover latency, throughput, full/drop,
// afull, simultaneous traffic with pointer wrap, and mid-operation reset.
module tb_hsyncfifo_fwft;

    localparam int unsigned DW  = 24;
    localparam int unsigned DEP = 16;
    localparam int unsigned TH  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hsyncfifo_if #(.DATA_W(DW), .DEPTH(DEP)) bus ();

    hsyncfifo_fwft #(
        .DATA_W   (DW),
        .DEPTH    (DEP),
        .AFULL_TH (TH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [DW-1:0] di, input logic re);
        bus.we = we;
        bus.di = di;
        bus.re = re;
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid & re
    always @(negedge clk) begin
        if (!rst && bus.valid && bus.re) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no word", bus.dout);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pop_data", 32'(bus.dout), 32'(mon_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        int lvl_bad;
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state, then single-word fall-through latency
        check("rst_valid", 32'(bus.valid), 32'(0));
        check("rst_level", 32'(bus.level), 32'(0));
        check("rst_empty", 32'(bus.empty_flag), 32'(1));
        check("rst_dout", 32'(bus.dout), 32'(0));
        check("rst_full", 32'(bus.full_flag), 32'(0));
        check("rst_afull", 32'(bus.afull), 32'(0));
        drive(1'b1, 24'hA5A5A5, 1'b0);
        exp_q.push_back(24'hA5A5A5);
        step();
        drive(1'b0, '0, 1'b0);
        check("lat_n_valid", 32'(bus.valid), 32'(0));
        check("lat_n_level", 32'(bus.level), 32'(1));
        step();
        check("lat_n1_valid", 32'(bus.valid), 32'(0));
        step();
        check("lat_n2_valid", 32'(bus.valid), 32'(1));
        check("lat_n2_dout", 32'(bus.dout), 32'h00A5A5A5);
        check("lat_n2_level", 32'(bus.level), 32'(1));
        drive(1'b0, '0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        check("lat_pop_valid", 32'(bus.valid), 32'(0));
        check("lat_pop_level", 32'(bus.level), 32'(0));
        step();

        // Streaming 0..99 with re held high: no bubbles after the first word
        gaps = 0;
        for (int i = 0; i < 103; i++) begin
            if (i < 100) begin
                drive(1'b1, DW'(i), 1'b1);
                exp_q.push_back(DW'(i));
            end else begin
                drive(1'b0, '0, 1'b1);
            end
            step();
            if (i >= 2 && i <= 101 && !bus.valid) gaps++;
        end
        drive(1'b0, '0, 1'b0);
        check("stream_gaps", 32'(gaps), 32'(0));
        check("stream_end_valid", 32'(bus.valid), 32'(0));
        check("stream_end_level", 32'(bus.level), 32'(0));
        check("stream_queue", 32'(exp_q.size()), 32'(0));
`ifdef HSYNCFIFO_ERR_FLAG_EN
        check("stream_udf", 32'(bus.udf), 32'(1));
`endif
        step();

        // Fill past capacity: 16 core + 2 prefetch accepted, last two dropped
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, DW'(100 + i), 1'b0);
            if (i < 18) exp_q.push_back(DW'(100 + i));
            step();
            if (i == 8)  check("afull_below", 32'(bus.afull), 32'(0));
            if (i == 9)  check("afull_rise", 32'(bus.afull), 32'(1));
            if (i == 16) check("full_at17", 32'(bus.full_flag), 32'(0));
            if (i == 17) check("full_at18", 32'(bus.full_flag), 32'(1));
        end
        drive(1'b0, '0, 1'b0);
        step();
        check("full_level", 32'(bus.level), 32'(18));
        check("full_flag", 32'(bus.full_flag), 32'(1));
        check("full_head", 32'(bus.dout), 32'(100));
        check("full_valid", 32'(bus.valid), 32'(1));
`ifdef HSYNCFIFO_ERR_FLAG_EN
        check("full_ovf", 32'(bus.ovf), 32'(1));
`endif
        // Drain: level and afull tracked per pop
        drive(1'b0, '0, 1'b1);
        for (int k = 1; k <= 18; k++) begin
            step();
            check("drain_level", 32'(bus.level), 32'(18 - k));
            check("drain_afull", 32'(bus.afull), ((18 - k) >= 10) ? 32'(1) : 32'(0));
            if (k == 1) check("drain_full_clr", 32'(bus.full_flag), 32'(0));
        end
        drive(1'b0, '0, 1'b0);
        check("drain_valid", 32'(bus.valid), 32'(0));
        check("drain_empty", 32'(bus.empty_flag), 32'(1));
        check("drain_queue", 32'(exp_q.size()), 32'(0));
        step();

        // Simultaneous write+pop at level 5 for 50 cycles, wrapping pointers
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, DW'(200 + i), 1'b0);
            exp_q.push_back(DW'(200 + i));
            step();
        end
        drive(1'b0, '0, 1'b0);
        step();
        step();
        step();
        check("sim_level_pre", 32'(bus.level), 32'(5));
        lvl_bad = 0;
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, DW'(205 + i), 1'b1);
            exp_q.push_back(DW'(205 + i));
            step();
            if (bus.level != 5'(5)) lvl_bad++;
        end
        check("sim_level_hold", 32'(lvl_bad), 32'(0));
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step();
        drive(1'b0, '0, 1'b0);
        check("sim_end_valid", 32'(bus.valid), 32'(0));
        check("sim_end_level", 32'(bus.level), 32'(0));
        check("sim_queue", 32'(exp_q.size()), 32'(0));
        step();

        // Reset at level 12 with a read in flight
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, DW'(300 + i), 1'b0);
            exp_q.push_back(DW'(300 + i));
            step();
        end
        drive(1'b0, '0, 1'b0);
        step();
        step();
        step();
        drive(1'b1, DW'(312), 1'b1);
        exp_q.push_back(DW'(312));
        step();
        check("rst2_level_pre", 32'(bus.level), 32'(12));
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        step();
        exp_q.delete();
        rst = 1'b0;
        check("rst2_valid", 32'(bus.valid), 32'(0));
        check("rst2_dout", 32'(bus.dout), 32'(0));
        check("rst2_level", 32'(bus.level), 32'(0));
        check("rst2_empty", 32'(bus.empty_flag), 32'(1));
        check("rst2_full", 32'(bus.full_flag), 32'(0));
        check("rst2_afull", 32'(bus.afull), 32'(0));
`ifdef HSYNCFIFO_ERR_FLAG_EN
        check("rst2_ovf", 32'(bus.ovf), 32'(0));
        check("rst2_udf", 32'(bus.udf), 32'(0));
`endif
        step();
        check("rst2_no_stale", 32'(bus.valid), 32'(0));
        drive(1'b1, 24'h777777, 1'b0);
        exp_q.push_back(24'h777777);
        step();
        drive(1'b0, '0, 1'b0);
        step();
        step();
        check("rst2_new_valid", 32'(bus.valid), 32'(1));
        check("rst2_new_dout", 32'(bus.dout), 32'h00777777);
        check("rst2_new_level", 32'(bus.level), 32'(1));
        drive(1'b0, '0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        check("rst2_end_valid", 32'(bus.valid), 32'(0));
        check("final_queue", 32'(exp_q.size()), 32'(0));
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hsyncfifo_fwft.md
# hsyncfifo_fwft

Parametrised first-word-fall-through synchronous FIFO for line buffering in the Sobel line-buffer path. It replaces fixed 2048x24 show-ahead FIFOs with a generic-width, generic-depth block. It has its own inferred RAM with 1-cycle registered read, a two-entry prefetch stage for full 1-word/cycle throughput, a programmable almost-full threshold and a fill-level output. Sobel line buffers instantiate one per delayed row; `afull` marks "one line stored".

## Interface
- `DATA_W`, 24, word width in bits
- `DEPTH`, 2048, core RAM depth; power of 2, >= 4
- `AFULL_TH`, 1920, `afull` threshold on `level`; 1..DEPTH
- `clk` in 1, single clock, all logic on rising edge
- `rst` in 1, synchronous, active-high reset
- `we` in 1, write strobe
- `di` in DATA_W, write data
- `re` in 1, pop the word currently on `dout`
- `dout` out DATA_W, head word; valid when `valid`=1; registered
- `valid` out 1, `dout` holds a word
- `empty_flag` out 1, equals ~`valid`
- `full_flag` out 1, core RAM holds DEPTH words
- `afull` out 1, `level` >= AFULL_TH
- `level` out $clog2(DEPTH+3), words held: core + in-flight + prefetch stage

## Operation
- Storage: core RAM with write/read pointers of $clog2(DEPTH) bits that wrap naturally, plus a core count of 0..DEPTH.
- Writes:
  - `we` & ~`full_flag`: write `di` at the write pointer, then increment it.
  - `we` & `full_flag`: drop the word; no state change.
- Prefetch stage: head register (`dout`/`valid`) plus one skid register.
- Pops:
  - `re` & `valid`: pop the head. If the skid register holds a word, it moves into the head.
  - `re` & ~`valid`: ignored.
- Core reads: issue one when core count != 0 and (prefetch occupancy + in-flight reads − pop this cycle) < 2. This guarantees no overflow of the prefetch stage.
- Returning RAM data goes to the head if the head is empty or being popped with the skid empty. Otherwise it goes to the skid.
- Ordering is strict FIFO across core, in-flight and prefetch.
- Capacity: `level` max = DEPTH+2.
- Flags:
  - `full_flag` reflects the core RAM only.
  - `afull` = (`level` >= AFULL_TH), registered.
- Simultaneous `we` and `re` are always legal. `level` changes by (+accepted write) − (pop).
- Flags are computed from registered state. A write in the same cycle as a pop while `full_flag`=1 is still dropped.

## Timing
- Reset: on `rst` at a clock edge, pointers, counts, `level`=0, `valid`=0, `empty_flag`=1, `full_flag`=0, `afull`=0, `dout`=0. The skid register and in-flight read are discarded. This is the same behaviour mid-operation; stored data is lost.
- Fall-through latency: word written at edge N to an empty FIFO gives `valid`=1 and `dout`=word after edge N+2.
- Steady state: with `re` held high and the FIFO non-empty, one word pops per cycle with no bubbles.
- `level`, `full_flag` and `afull` update on the edge following the causing `we`/`re`.
- `dout` holds its value while `re`=0.

## Configuration
- Macro `HSYNCFIFO_ERR_FLAG_EN`.
- When defined, adds outputs `ovf` and `udf` (1 bit each, sticky, cleared only by `rst`):
  - `ovf` sets on `we` & `full_flag`.
  - `udf` sets on `re` & ~`valid`.
- When not defined, those ports and their logic are absent, and dropped writes and ignored reads are silent.

## Structure
- Package `hsyncfifo_pkg`:
  - `level` width function.
  - Prefetch occupancy type (0..2).
  - Default DATA_W/DEPTH/AFULL_TH constants shared by line-buffer instances.
- One sub-module, `hsyncfifo_ram`: simple dual-port RAM, DATA_W x DEPTH, registered 1-cycle read, no reset on the array.
- The top holds pointers, counts, the prefetch stage and flags.

## Test plan
- Reset then idle: `valid`=0, `level`=0, `empty_flag`=1, `dout`=0. After one write of 0xA5A5A5 at edge N, `valid`=1 and `dout`=0xA5A5A5 after edge N+2, with `level`=1.
- Continuous write of 0..99 with `re` held high: output is 0..99 in order, one per cycle, with no gaps after the first word.
- DEPTH=16: write 20 words with no reads. `full_flag` goes high at `level`=18 (16 core + 2 prefetch). Words 18 and 19 are dropped; `ovf`=1 when enabled. Draining yields words 0..17.
- AFULL_TH=10: `afull` rises on the edge after the 10th accepted write. It falls on the edge after `level` drops to 9.
- Simultaneous `we`/`re` at `level`=5 for 50 cycles: `level` stays 5, data order is preserved, and pointers wrap correctly past DEPTH.
- Assert `rst` with `level`=12 and an in-flight read: the next cycle has all outputs at reset values. A subsequent write/read returns only the new data.
